video_sync_v: RTL and testbench

VIDEO_SYNC_V -- requirements
Module: video_sync_v

---
 rtl/video_timing_pkg.sv | 50 +++++
 rtl/video_sync_v_if.sv | 25 ++
 rtl/video_sync_v.sv | 71 +++++++
 tb/tb_video_sync_v.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants for the horizontal and vertical sync stages.
package video_timing_pkg;

    localparam int unsigned VCOUNT_W = 9;

    // Horizontal stage constants (video clocks per line)
    localparam int unsigned H_TOTAL      = 448;
    localparam int unsigned H_SYNC_BEG   = 328;
    localparam int unsigned H_SYNC_END   = 360;

    // Vertical line decode points
    localparam logic [VCOUNT_W-1:0] V_BLANK_BEG   = 9'd0;
    localparam logic [VCOUNT_W-1:0] V_SYNC_BEG    = 9'd8;
    localparam logic [VCOUNT_W-1:0] V_SYNC_END    = 9'd11;
    localparam logic [VCOUNT_W-1:0] V_BLANK_END   = 9'd32;
    localparam logic [VCOUNT_W-1:0] VPIX_BEG_ATM  = 9'd56;
    localparam logic [VCOUNT_W-1:0] VPIX_BEG_PENT = 9'd76;
    localparam logic [VCOUNT_W-1:0] VPIX_END_PENT = 9'd268;
    localparam logic [VCOUNT_W-1:0] VPIX_END_ATM  = 9'd296;

    // Frame lengths and INT lines
    localparam logic [VCOUNT_W-1:0] FRAME_LEN_PENT = 9'd320;
    localparam logic [VCOUNT_W-1:0] FRAME_LEN_48K  = 9'd312;
    localparam logic [VCOUNT_W-1:0] FRAME_LEN_128K = 9'd311;
    localparam logic [VCOUNT_W-1:0] INT_LINE_DEF   = 9'd0;
    localparam logic [VCOUNT_W-1:0] INT_LINE_128K  = 9'd1;

    typedef enum logic [1:0] {
        RASTER_PENT_A = 2'b00,
        RASTER_PENT_B = 2'b01,
        RASTER_48K    = 2'b10,
        RASTER_128K   = 2'b11
    } raster_e;

    // Last line number of the frame for a raster mode
    function automatic logic [VCOUNT_W-1:0] frame_last(input logic [1:0] raster);
        logic [VCOUNT_W-1:0] len;
        case (raster)
            RASTER_48K:  len = FRAME_LEN_48K;
            RASTER_128K: len = FRAME_LEN_128K;
            default:     len = FRAME_LEN_PENT;
        endcase
        return len - 9'd1;
    endfunction

    function automatic logic [VCOUNT_W-1:0] int_line(input logic [1:0] raster);
        return (raster == RASTER_128K) ? INT_LINE_128K : INT_LINE_DEF;
    endfunction

endpackage

// File: rtl/video_sync_v_if.sv
// Strobe inputs and vertical timing outputs of the vertical sync stage.
interface video_sync_v_if;
    logic       hsync_start;
    logic       line_start;
    logic       hint_start;
    logic       mode_atm_n_pent;
    logic [1:0] modes_raster;
    logic       vblank;
    logic       vsync;
    logic       vpix;
    logic       int_start;
    logic       frame_start;
    logic       pix_line_start;
    logic [8:0] vcount;

    modport master (
        output hsync_start, line_start, hint_start, mode_atm_n_pent, modes_raster,
        input  vblank, vsync, vpix, int_start, frame_start, pix_line_start, vcount
    );

    modport slave (
        input  hsync_start, line_start, hint_start, mode_atm_n_pent, modes_raster,
        output vblank, vsync, vpix, int_start, frame_start, pix_line_start, vcount
    );
endinterface

// File: rtl/video_sync_v.sv
// Vertical sync stage: line counter, blank/sync/pixel windows and per-frame strobes.
module video_sync_v
    import video_timing_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    video_sync_v_if.slave vs
);

    logic [VCOUNT_W-1:0] vcount_q;
    logic                vblank_q;
    logic                vsync_q;
    logic                vpix_q;
    logic                int_start_q;
    logic                frame_start_q;
    logic                pix_line_start_q;

    logic                wrap_c;
    logic [VCOUNT_W-1:0] vpix_beg_c;
    logic [VCOUNT_W-1:0] vpix_end_c;

    // >= so a switch to a shorter frame past its end still wraps at once
    always_comb begin
        wrap_c     = 1'b0;
        vpix_beg_c = VPIX_BEG_PENT;
        vpix_end_c = VPIX_END_PENT;
        wrap_c = (vcount_q >= frame_last(vs.modes_raster));
        if (vs.mode_atm_n_pent) begin
            vpix_beg_c = VPIX_BEG_ATM;
            vpix_end_c = VPIX_END_ATM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vcount_q         <= '0;
            vblank_q         <= 1'b0;
            vsync_q          <= 1'b0;
            vpix_q           <= 1'b0;
            int_start_q      <= 1'b0;
            frame_start_q    <= 1'b0;
            pix_line_start_q <= 1'b0;
        end else begin
            frame_start_q    <= vs.hsync_start && wrap_c;
            int_start_q      <= vs.hint_start && (vcount_q == int_line(vs.modes_raster));
            pix_line_start_q <= vs.line_start && vpix_q;
            if (vs.hsync_start) begin
                vcount_q <= wrap_c ? '0 : vcount_q + 9'd1;

                if (vcount_q == V_BLANK_BEG)      vblank_q <= 1'b1;
                else if (vcount_q == V_BLANK_END) vblank_q <= 1'b0;

                if (vcount_q == V_SYNC_BEG)      vsync_q <= 1'b1;
                else if (vcount_q == V_SYNC_END) vsync_q <= 1'b0;

                // Clear has priority if a mode change makes both points coincide
                if (vcount_q == vpix_end_c)      vpix_q <= 1'b0;
                else if (vcount_q == vpix_beg_c) vpix_q <= 1'b1;
            end
        end
    end

    assign vs.vcount         = vcount_q;
    assign vs.vblank         = vblank_q;
    assign vs.vsync          = vsync_q;
    assign vs.vpix           = vpix_q;
    assign vs.int_start      = int_start_q;
    assign vs.frame_start    = frame_start_q;
    assign vs.pix_line_start = pix_line_start_q;

endmodule

// File: tb/tb_video_sync_v.sv
// Self-checking bench for video_sync_v: reference model feeding a scoreboard queue.
module tb_video_sync_v;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    video_sync_v_if vs();
    video_sync_v dut (.clk(clk), .rst_n(rst_n), .vs(vs));

    typedef struct packed {
        logic [8:0] vcount;
        logic       vblank;
        logic       vsync;
        logic       vpix;
        logic       int_start;
        logic       frame_start;
        logic       pix_line_start;
    } out_t;

    typedef struct {
        bit   hs;
        bit   ls;
        bit   hi;
        out_t exp;
    } vec_t;

    int   checks = 0;
    int   passed = 0;
    out_t sb_q[$];

    bit       atm;
    bit [1:0] raster;
    int       m_vc;
    bit       m_vb, m_vs, m_vp;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic out_t read_out();
        out_t o;
        o.vcount         = vs.vcount;
        o.vblank         = vs.vblank;
        o.vsync          = vs.vsync;
        o.vpix           = vs.vpix;
        o.int_start      = vs.int_start;
        o.frame_start    = vs.frame_start;
        o.pix_line_start = vs.pix_line_start;
        return o;
    endfunction

    function automatic vec_t mk(bit hs, bit ls, bit hi, int vc, bit vb, bit vsy, bit vp,
                                bit is, bit fs, bit ps);
        vec_t v;
        v.hs = hs; v.ls = ls; v.hi = hi;
        v.exp.vcount = 9'(vc);
        v.exp.vblank = vb; v.exp.vsync = vsy; v.exp.vpix = vp;
        v.exp.int_start = is; v.exp.frame_start = fs; v.exp.pix_line_start = ps;
        return v;
    endfunction

    task automatic model_reset();
        m_vc = 0; m_vb = 0; m_vs = 0; m_vp = 0;
    endtask

    task automatic model_step(input bit hs, input bit ls, input bit hi, output out_t o);
        int len, il, beg, en;
        len = (raster == 2'b10) ? 312 : (raster == 2'b11) ? 311 : 320;
        il  = (raster == 2'b11) ? 1 : 0;
        beg = atm ? 56 : 76;
        en  = atm ? 296 : 268;
        o = '0;
        o.int_start      = hi && (m_vc == il);
        o.frame_start    = hs && (m_vc >= len - 1);
        o.pix_line_start = ls && m_vp;
        if (hs) begin
            if (m_vc == 0) m_vb = 1; else if (m_vc == 32) m_vb = 0;
            if (m_vc == 8) m_vs = 1; else if (m_vc == 11) m_vs = 0;
            if (m_vc == en) m_vp = 0; else if (m_vc == beg) m_vp = 1;
            m_vc = (m_vc >= len - 1) ? 0 : m_vc + 1;
        end
        o.vcount = 9'(m_vc);
        o.vblank = m_vb; o.vsync = m_vs; o.vpix = m_vp;
    endtask

    task automatic set_mode(input bit a, input bit [1:0] r);
        atm = a; raster = r;
        vs.mode_atm_n_pent = a;
        vs.modes_raster    = r;
    endtask

    // Called right after a falling edge; DUT samples on the next rising edge.
    task automatic drive(input string name, input bit hs, input bit ls, input bit hi,
                         input bit use_tab, input out_t tab_exp, output out_t act);
        out_t m, e;
        model_step(hs, ls, hi, m);
        sb_q.push_back(use_tab ? tab_exp : m);
        vs.hsync_start = hs; vs.line_start = ls; vs.hint_start = hi;
        @(negedge clk);
        act = read_out();
        vs.hsync_start = 0; vs.line_start = 0; vs.hint_start = 0;
        e = sb_q.pop_front();
        checks++;
        if (act === e) passed++;
        else $display("FAIL %s vc=%0d: got %h expected %h", name, m_vc, act, e);
    endtask

    task automatic run_line(output out_t a, output out_t b);
        drive("line_hs", 1, 0, 0, 0, '0, a);
        drive("line_ls_hi", 0, 1, 1, 0, '0, b);
    endtask

    task automatic run_frame(output int lines, output int ints, output int pix,
                             output int vp, output int maxvc);
        out_t a, b;
        bit done = 0;
        lines = 0; ints = 0; pix = 0; vp = 0; maxvc = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            run_line(a, b);
            lines++;
            ints += int'(a.int_start) + int'(b.int_start);
            pix  += int'(b.pix_line_start);
            vp   += int'(a.vpix);
            if (int'(a.vcount) > maxvc) maxvc = int'(a.vcount);
            if (a.frame_start) done = 1;
        end
        if (!done) check("frame_timeout", 0, 1);
    endtask

    task automatic run_to_line(input int target);
        out_t a, b;
        for (int i = 0; i < 400 && m_vc != target; i++) run_line(a, b);
        if (m_vc != target) check("line_timeout", m_vc, target);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[6];
        out_t a, b;
        int   fs_idx[$];
        int   vb_cnt, vsy_cnt, lines, ints, pix, vp, maxvc;

        rst_n = 0;
        vs.hsync_start = 0; vs.line_start = 0; vs.hint_start = 0;
        set_mode(0, 2'b00);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", int'(read_out()), 0);
        rst_n = 1;
        @(negedge clk);

        // Coincident hsync+hint at line 0, then hint/line_start off their lines
        tab[0] = mk(1, 0, 1, 1, 1, 0, 0, 1, 0, 0);
        tab[1] = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        tab[2] = mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        tab[3] = mk(1, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        tab[4] = mk(1, 1, 0, 3, 1, 0, 0, 0, 0, 0);
        tab[5] = mk(0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive("table", tab[i].hs, tab[i].ls, tab[i].hi, 1, tab[i].exp, a);

        // 320-line frame: frame period, blank and sync widths
        vb_cnt = 0; vsy_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            run_line(a, b);
            if (a.frame_start) fs_idx.push_back(i);
            else if (fs_idx.size() == 1) begin
                vb_cnt  += int'(a.vblank);
                vsy_cnt += int'(a.vsync);
            end
        end
        check("frame_start_count", fs_idx.size(), 2);
        if (fs_idx.size() >= 2) check("frame_period", fs_idx[1] - fs_idx[0], 320);
        check("vblank_lines", vb_cnt, 32);
        check("vsync_lines", vsy_cnt, 3);

        // Pixel windows, starting aligned to a frame boundary
        run_to_line(0);
        run_frame(lines, ints, pix, vp, maxvc);
        check("pent_lines", lines, 320);
        check("pent_vpix", vp, 192);
        check("pent_pix_starts", pix, 192);
        set_mode(1, 2'b00);
        run_frame(lines, ints, pix, vp, maxvc);
        check("atm_vpix", vp, 240);
        check("atm_pix_starts", pix, 240);

        // 311-line frame: wrap point and INT on line 1
        set_mode(0, 2'b11);
        run_frame(lines, ints, pix, vp, maxvc);
        check("r128_lines", lines, 311);
        check("r128_ints", ints, 1);
        check("r128_maxvc", maxvc, 310);

        // Switch to 312 lines while beyond its end
        set_mode(0, 2'b00);
        run_to_line(315);
        set_mode(0, 2'b10);
        drive("short_switch", 1, 0, 0, 0, '0, a);
        check("short_switch_vcount", int'(a.vcount), 0);
        check("short_switch_fs", int'(a.frame_start), 1);

        // Mid-frame asynchronous reset
        set_mode(0, 2'b00);
        run_to_line(100);
        check("vpix_before_reset", int'(vs.vpix), 1);
        rst_n = 0;
        #1;
        check("async_reset_outputs", int'(read_out()), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        drive("post_reset", 1, 0, 0, 0, '0, a);
        check("post_reset_vcount", int'(a.vcount), 1);
        check("post_reset_vblank", int'(a.vblank), 1);
        check("post_reset_fs", int'(a.frame_start), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
